// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sequencer: wave codes, FSM states and the
// packed segment-entry layout {wave, inc, dwell} used on cfg_wdata.
package awg_pkg;

  localparam logic [1:0] SAW = 2'd0;
  localparam logic [1:0] TRI = 2'd1;
  localparam logic [1:0] SQR = 2'd2;
  localparam logic [1:0] SIN = 2'd3;

  localparam int WAVE_W    = 2;
  localparam int DWELL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  function automatic int inc_lsb(input int dwell_w);
    return dwell_w;
  endfunction

  function automatic int wave_lsb(input int phase_w, input int dwell_w);
    return phase_w + dwell_w;
  endfunction

  function automatic int entry_w(input int phase_w, input int dwell_w);
    return WAVE_W + phase_w + dwell_w;
  endfunction

endpackage

// File: rtl/awg_seq_table.sv
// Segment table: N_ENTRY-deep register file, async reset, synchronous write,
// combinational read (a same-edge write is seen by the reader only afterwards).
module awg_seq_table
  import awg_pkg::*;
#(
  parameter int N_ENTRY = 4,
  parameter int ENTRY_W = 42
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(N_ENTRY)-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]         wdata_i,
  input  logic [$clog2(N_ENTRY)-1:0] raddr_i,
  output logic [ENTRY_W-1:0]         rdata_o
);

  logic [ENTRY_W-1:0] mem_q [N_ENTRY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRY; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/awg_sequencer.sv
// Waveform segment scheduler; segments advance only on phase carry.
// Build option: define AWG_SEQ_ONESHOT_EN to stop after the last entry instead of looping.
module awg_sequencer
  import awg_pkg::*;
#(
  parameter int N_ENTRY = 4,
  parameter int PHASE_W = 16,
  parameter int DWELL_W = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_we_i,
  input  logic [$clog2(N_ENTRY)-1:0]          cfg_addr_i,
  input  logic [WAVE_W+PHASE_W+DWELL_W-1:0]   cfg_wdata_i,
  input  logic                                start_i,
  input  logic                                stop_i,
  output logic                                busy_o,
  output logic [1:0]                          wave_sel_o,
  output logic [3:0]                          wave_en_o,
  output logic [PHASE_W-1:0]                  phase_o,
  output logic                                seg_start_o,
  output logic                                done_o
);

  localparam int ADDR_W   = $clog2(N_ENTRY);
  localparam int ENTRY_W  = entry_w(PHASE_W, DWELL_W);
  localparam int INC_LSB  = inc_lsb(DWELL_W);
  localparam int WAVE_LSB = wave_lsb(PHASE_W, DWELL_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ENTRY - 1);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          wave_q, wave_d;
  logic [PHASE_W-1:0]  inc_q, inc_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                seg_start_q, seg_start_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0]  rd_data;
  logic [PHASE_W:0]    sum, sum_d;
  logic                wrap, load, clear;

  awg_seq_table #(
    .N_ENTRY (N_ENTRY),
    .ENTRY_W (ENTRY_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_we_i),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_wdata_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // done is registered, so it is predicted from the next-state carry condition.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wave_d      = wave_q;
    inc_d       = inc_q;
    dwell_d     = dwell_q;
    phase_d     = phase_q;
    seg_start_d = 1'b0;
    load        = 1'b0;
    clear       = 1'b0;
    rd_addr     = (state_q == IDLE) ? '0 : idx_q + 1'b1;
    sum         = {1'b0, phase_q} + {1'b0, inc_q};
    wrap        = sum[PHASE_W] || (inc_q == '0);

    case (state_q)
      IDLE: load = start_i;
      RUN: begin
        phase_d = sum[PHASE_W-1:0];
        if (dwell_q == DWELL_W'(1)) state_d = DRAIN;
        else if (dwell_q != '0)     dwell_d = dwell_q - 1'b1;
      end
      DRAIN: begin
        if (!wrap) begin
          phase_d = sum[PHASE_W-1:0];
        end else if (idx_q != LAST) begin
          load = 1'b1;
        end else begin
`ifdef AWG_SEQ_ONESHOT_EN
          clear = 1'b1;
`else
          load = 1'b1;
`endif
        end
      end
      default: clear = 1'b1;
    endcase

    if (load) begin
      state_d     = RUN;
      idx_d       = rd_addr;
      wave_d      = rd_data[WAVE_LSB +: WAVE_W];
      inc_d       = rd_data[INC_LSB +: PHASE_W];
      dwell_d     = rd_data[DWELL_LSB +: DWELL_W];
      phase_d     = '0;
      seg_start_d = 1'b1;
    end

    if (clear || stop_i) begin
      state_d     = IDLE;
      idx_d       = '0;
      wave_d      = SAW;
      inc_d       = '0;
      dwell_d     = '0;
      phase_d     = '0;
      seg_start_d = 1'b0;
    end

    sum_d  = {1'b0, phase_d} + {1'b0, inc_d};
    done_d = (state_d == DRAIN) && (idx_d == LAST) && (sum_d[PHASE_W] || (inc_d == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wave_q      <= SAW;
      inc_q       <= '0;
      dwell_q     <= '0;
      phase_q     <= '0;
      seg_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wave_q      <= wave_d;
      inc_q       <= inc_d;
      dwell_q     <= dwell_d;
      phase_q     <= phase_d;
      seg_start_q <= seg_start_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    wave_en_o = 4'b0000;
    if (state_q != IDLE) begin
      case (wave_q)
        SAW:     wave_en_o = 4'b0001;
        TRI:     wave_en_o = 4'b0010;
        SQR:     wave_en_o = 4'b0100;
        SIN:     wave_en_o = 4'b1000;
        default: wave_en_o = 4'b0000;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign wave_sel_o  = wave_q;
  assign phase_o     = phase_q;
  assign seg_start_o = seg_start_q;
  assign done_o      = done_q;

endmodule

// File: doc/awg_sequencer.md
# awg_sequencer

Programmable waveform scheduler for the single-channel AWG. Steps through a small table of segments (waveform select, phase increment, dwell time), driving the one-hot generator enables, waveform select and phase accumulator that feed the saw/tri/sqr/sin generators and DAC register. Segment changes happen only at phase wrap, so output waveforms switch on a period boundary without glitches.

## Interface
- N_ENTRY, 4: segment table depth; power of two, at least 2.
- PHASE_W, 16: phase accumulator and increment width.
- DWELL_W, 24: dwell counter width, in clk cycles.
- clk  in  1  system clock; the DAC clock domain.
- rst  in  1  reset; asynchronous, active-high.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(N_ENTRY)  table entry index.
- cfg_wdata  in  2+PHASE_W+DWELL_W  packed as {wave[1:0], inc, dwell}.
- start  in  1  begin the sequence at entry 0; level-sampled.
- stop  in  1  abort to idle.
- busy  out  1  high in RUN or DRAIN.
- wave_sel  out  2  wave code: 0 saw, 1 tri, 2 sqr, 3 sin.
- wave_en  out  4  one-hot enable, equal to 1<<wave_sel when busy; 0 when idle.
- phase  out  PHASE_W  accumulator value; sin address, saw/tri/sqr count.
- seg_start  out  1  one-cycle pulse on the first cycle of every segment.
- done  out  1  one-cycle pulse on the cycle the last entry completes.

## Operation
- States: IDLE, RUN, DRAIN. Reset values: state IDLE, every table entry 0, all outputs 0.
- IDLE:
  - phase=0, wave_en=0.
  - start=1 → RUN with entry 0.
- Entering RUN with entry k:
  - Latch wave, inc and dwell from the table via a combinational read.
  - Set phase=0 and seg_start=1.
  - Update wave_sel and wave_en.
- RUN:
  - phase += inc each cycle, modulo 2^PHASE_W.
  - dwell_cnt decrements each cycle.
  - RUN lasts exactly dwell cycles, then → DRAIN.
  - dwell=0 means hold the segment indefinitely, until stop.
- DRAIN:
  - phase keeps accumulating.
  - On the cycle where phase+inc carries out of PHASE_W, the next cycle is RUN with entry (k+1) mod N_ENTRY. The new phase is 0, with no gap cycle.
  - inc=0 in DRAIN advances on the next cycle.
- Last entry (N_ENTRY-1) completing: done pulses on its carry cycle, then behaviour follows Configuration.
- stop=1 in any state → IDLE on the next edge, with phase, wave_en, wave_sel and busy cleared. stop wins over a simultaneous start. start while busy is ignored.
- Table writes are accepted in any state.
  - Latched segment parameters are unaffected; a new value takes effect the next time that entry is loaded.
  - A write to entry j on the same edge that loads j: the old value is loaded.
- Reset asserted mid-operation: immediate return to the reset values, including the table.

## Timing
- start sampled high at edge t → at t+1: busy=1, seg_start=1, phase=0, wave_en valid.
- Segment length = dwell cycles + DRAIN cycles up to and including the carry cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- seg_start and done are never high for more than one consecutive cycle, except seg_start when entries advance on consecutive cycles.

## Configuration
- AWG_SEQ_ONESHOT_EN defined: after done, go to IDLE on the next cycle, with outputs cleared as for stop.
- AWG_SEQ_ONESHOT_EN undefined: after done, continue with entry 0 (seg_start pulses) and loop until stop.

## Structure
- Shared package awg_pkg holds:
  - wave code constants (SAW=0, TRI=1, SQR=2, SIN=3);
  - the sequencer state enum;
  - the packed entry field widths and offsets used for cfg_wdata.
- One sub-module, awg_seq_table: an N_ENTRY-deep register file with async reset, a synchronous write port and a combinational read port.

## Test plan
- Reset: assert rst mid-RUN → all outputs 0 immediately. Read-back through a start shows entry 0 with inc=0 and dwell=0 holding phase=0 and wave_en=0001.
- Basic segment: entry0={sin, 0x4000, 3}, entry1={saw, 0x1000, 2}, start → phase 0, 0x4000, 0x8000 (RUN), 0xC000 (DRAIN carry), then 0 with seg_start=1, wave_en=0001, wave_sel=0.
- Loop and done: fill all 4 entries, macro undefined → done pulses once per pass and entry 0 reloads. Macro defined → IDLE and busy=0 one cycle after done.
- Stop: stop mid-DRAIN → next cycle busy=0, phase=0, wave_en=0. start and stop in the same cycle from IDLE → stays IDLE.
- Hold and edge cases: dwell=0 → never advances over 10^5 cycles. inc=0 with dwell=2 → advances after 3 cycles.
- Write collision: rewrite entry 1 while entry 0 is in DRAIN, on the carry edge → old entry-1 values are used for this pass and new values on the next pass.
